alu_sin_deframer: RTL and testbench

Serial-input front end of the serial ALU. Samples `sin` one bit per clock and recovers 11-bit frames: start 0, type bit, 8-bit payload, stop 1. Assembles a packet of 8 data bytes (B MSB-first, then A MSB-first) followed by one control byte, then checks the packet. Emits either a one-cycle valid pulse with A/B/opcode to the ALU core, or a one-cycle error pulse with error flags to the response serializer.

---
 rtl/alu_sin_deframer.sv | 175 +++++++++++++++++
 tb/tb_alu_sin_deframer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sin_deframer.sv
// Serial-input deframer for the serial ALU: 11-bit frames -> 8 data bytes + control byte -> checked packet.
// Optional macro SIN_FRAME_CHECK_EN rejects the packet when a stop bit is sampled as 0.
module alu_sin_deframer #(
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  op_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [2:0]  err_flags_o
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CRC_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NBYTES = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned WORD_W = 2 * DATA_W + 1 + OP_W;
    localparam int unsigned TMO_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [2:0]       ERR_DATA = 3'b100;
    localparam logic [2:0]       ERR_CRC  = 3'b010;
    localparam logic [2:0]       ERR_OP   = 3'b001;
    localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_BREAK} state_t;

    state_t                  state_q, state_d;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BYTE_W-1:0]       shreg;
    logic                    frm_ctl;
    logic                    done_q;
    logic                    bad_stop;
    logic [CNT_W-1:0]        pkt_cnt;
    logic [2*DATA_W-1:0]     data_q;
    logic                    timeout_c;
    logic [CRC_W-1:0]        crc_c;
    logic [OP_W-1:0]         op_c;
    logic                    op_legal_c;

    // CRC-4, x^4+x+1, zero init, MSB first
    function automatic logic [CRC_W-1:0] crc4(input logic [WORD_W-1:0] word);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = '0;
        for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ word[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!sin) state_d = S_TYPE;
            S_TYPE:    state_d = S_PAYLOAD;
            S_PAYLOAD: if (bit_cnt == BIT_W'(BYTE_W - 1)) state_d = S_STOP;
`ifdef SIN_FRAME_CHECK_EN
            S_STOP:    state_d = sin ? S_IDLE : S_BREAK;
`else
            S_STOP:    state_d = S_IDLE;
`endif
            S_BREAK:   if (sin) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Frame datapath; done_q marks the cycle after a stop bit was sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            frm_ctl <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_STOP);
            if (state_q == S_TYPE) frm_ctl <= sin;
            if (state_q == S_PAYLOAD) begin
                shreg   <= {shreg[BYTE_W-2:0], sin};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

`ifdef SIN_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bad_stop <= 1'b0;
        else        bad_stop <= (state_q == S_STOP) && !sin;
    end
`else
    assign bad_stop = 1'b0;
`endif

    assign op_c       = shreg[CRC_W+OP_W-1:CRC_W];
    assign crc_c      = crc4({data_q, 1'b1, op_c});
    assign op_legal_c = op_c inside {3'b000, 3'b001, 3'b100, 3'b101};

    if (IDLE_TIMEOUT > 0) begin : g_timeout
        logic [TMO_W-1:0] idle_cnt;
        logic             idling_c;
        assign idling_c = (state_q == S_IDLE) && sin;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                idle_cnt <= '0;
            else if (!idling_c)                        idle_cnt <= '0;
            else if (idle_cnt != TMO_W'(IDLE_TIMEOUT)) idle_cnt <= idle_cnt + TMO_W'(1);
        end
        assign timeout_c = idling_c && (idle_cnt == TMO_W'(IDLE_TIMEOUT - 1)) && (pkt_cnt != '0);
    end else begin : g_no_timeout
        assign timeout_c = 1'b0;
    end

    // Packet assembly, checks and one-cycle result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt     <= '0;
            data_q      <= '0;
            a_o         <= '0;
            b_o         <= '0;
            op_o        <= '0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= '0;
        end else begin
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= '0;
            if (done_q) begin
                if (bad_stop) begin
                    err_o       <= 1'b1;
                    err_flags_o <= ERR_DATA;
                    pkt_cnt     <= '0;
                end else if (!frm_ctl) begin
                    if (pkt_cnt < CNT_W'(NBYTES)) begin
                        data_q  <= {data_q[2*DATA_W-BYTE_W-1:0], shreg};
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                    end else begin
                        err_o       <= 1'b1;
                        err_flags_o <= ERR_DATA;
                        pkt_cnt     <= '0;
                    end
                end else begin
                    pkt_cnt <= '0;
                    if (pkt_cnt != CNT_W'(NBYTES)) begin
                        err_o       <= 1'b1;
                        err_flags_o <= ERR_DATA;
                    end else if (crc_c != shreg[CRC_W-1:0]) begin
                        err_o       <= 1'b1;
                        err_flags_o <= ERR_CRC;
                    end else if (!op_legal_c) begin
                        err_o       <= 1'b1;
                        err_flags_o <= ERR_OP;
                    end else begin
                        valid_o <= 1'b1;
                        a_o     <= data_q[DATA_W-1:0];
                        b_o     <= data_q[2*DATA_W-1:DATA_W];
                        op_o    <= op_c;
                    end
                end
            end else if (timeout_c) begin
                pkt_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sin_deframer.sv
// Self-checking bench for alu_sin_deframer: table-driven packets, scoreboard of expected pulses,
// hand sequences for timeout, mid-packet reset and stop-bit handling.
module tb_alu_sin_deframer;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_DATA = 3'b100;
    localparam logic [2:0] F_CRC  = 3'b010;
    localparam logic [2:0] F_OP   = 3'b001;
    localparam int NVEC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sin;
    logic [31:0] a_o, b_o;
    logic [2:0]  op_o;
    logic        valid_o, err_o;
    logic [2:0]  err_flags_o;

    alu_sin_deframer #(.IDLE_TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .a_o(a_o), .b_o(b_o), .op_o(op_o),
        .valid_o(valid_o), .err_o(err_o), .err_flags_o(err_flags_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc_add;
        int          ndata;
        logic        exp_valid;
        logic [2:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_stop = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [2:0]  m_op = '0;
    logic [63:0] w;
    logic [7:0]  ctl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC by polynomial long division of the augmented message
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic is_ctl, input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        send_bit(is_ctl);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(stop);
        last_stop = cyc + 2;
    endtask

    task automatic send_bytes(input logic [63:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) send_frame(1'b0, word[63-8*i -: 8], 1'b1);
    endtask

    task automatic push(input logic valid, input logic [31:0] b, input logic [31:0] a,
                        input logic [2:0] op, input logic [2:0] flags);
        exp_t x;
        x.valid = valid; x.b = b; x.a = a; x.op = op; x.flags = flags; x.cyc = last_stop;
        sb.push_back(x);
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        send_bytes({b, a}, 0, 7);
        send_frame(1'b1, {1'b0, op, crc_ref(b, a, op)}, 1'b1);
        push(1'b1, b, a, op, F_NONE);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_o"}, 64'(a_o), 64'd0);
        check({tag, "_b_o"}, 64'(b_o), 64'd0);
        check({tag, "_op_o"}, 64'(op_o), 64'd0);
        check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
        check({tag, "_err_o"}, 64'(err_o), 64'd0);
        check({tag, "_err_flags_o"}, 64'(err_flags_o), 64'd0);
    endtask

    // Output monitor: pulses checked against the scoreboard, holds checked every other cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
                check("missing_pulse_cycle", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (valid_o || err_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 64'({valid_o, err_o}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    check("valid_o", 64'(valid_o), 64'(e.valid));
                    check("err_o", 64'(err_o), 64'(!e.valid));
                    if (e.valid) begin
                        check("a_o", 64'(a_o), 64'(e.a));
                        check("b_o", 64'(b_o), 64'(e.b));
                        check("op_o", 64'(op_o), 64'(e.op));
                        check("flags_on_valid", 64'(err_flags_o), 64'd0);
                        m_a = e.a; m_b = e.b; m_op = e.op;
                    end else begin
                        check("err_flags_o", 64'(err_flags_o), 64'(e.flags));
                        check("a_o_held_on_err", 64'(a_o), 64'(m_a));
                        check("b_o_held_on_err", 64'(b_o), 64'(m_b));
                        check("op_o_held_on_err", 64'(op_o), 64'(m_op));
                    end
                end
            end else begin
                check("err_flags_idle", 64'(err_flags_o), 64'd0);
                check("a_o_hold", 64'(a_o), 64'(m_a));
                check("b_o_hold", 64'(b_o), 64'(m_b));
                check("op_o_hold", 64'(op_o), 64'(m_op));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 4'd0, 8, 1'b1, F_NONE};
        vecs[1] = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 4'd1, 8, 1'b0, F_CRC};
        vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 4'd0, 7, 1'b0, F_DATA};
        vecs[3] = '{32'hCAFE_BABE, 32'h0BAD_F00D, 3'b101, 4'd0, 8, 1'b1, F_NONE};
        vecs[4] = '{32'h55AA_55AA, 32'h1111_1111, 3'b111, 4'd0, 8, 1'b0, F_OP};
        vecs[5] = '{32'h55AA_55AA, 32'h1111_1111, 3'b111, 4'd5, 8, 1'b0, F_CRC};
        vecs[6] = '{32'hDEAD_BEEF, 32'h0123_4567, 3'b010, 4'd0, 8, 1'b0, F_OP};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 4'd0, 8, 1'b1, F_NONE};
        vecs[8] = '{32'h8000_0000, 32'h0000_0001, 3'b011, 4'd3, 8, 1'b0, F_CRC};
        vecs[9] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b110, 4'd0, 8, 1'b0, F_OP};

        sin   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        send_idle(4);

        // All-zero operands with the literal control byte {0,000,1011}
        send_bytes(64'd0, 0, 7);
        send_frame(1'b1, 8'b0000_1011, 1'b1);
        push(1'b1, 32'd0, 32'd0, 3'b000, F_NONE);

        for (int i = 0; i < NVEC; i++) begin
            w   = {vecs[i].b, vecs[i].a};
            send_bytes(w, 0, vecs[i].ndata - 1);
            ctl = {1'b0, vecs[i].op, crc_ref(vecs[i].b, vecs[i].a, vecs[i].op) + vecs[i].crc_add};
            send_frame(1'b1, ctl, 1'b1);
            push(vecs[i].exp_valid, vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].exp_flags);
        end

        // Ninth data byte on a full packet, then a CTL with count already cleared
        w = 64'h0102_0304_0506_0708;
        send_bytes(w, 0, 7);
        send_frame(1'b0, 8'hA5, 1'b1);
        push(1'b0, '0, '0, '0, F_DATA);
        send_frame(1'b1, {1'b0, 3'b000, crc_ref(w[63:32], w[31:0], 3'b000)}, 1'b1);
        push(1'b0, '0, '0, '0, F_DATA);
        send_packet(32'hA5A5_0001, 32'h5A5A_0002, 3'b101);

        // Timeout: 100 idle cycles drop a partial packet
        send_idle(3);
        send_bytes(64'h1111_2222_3333_4444, 0, 2);
        send_idle(100);
        send_packet(32'h7777_8888, 32'h9999_AAAA, 3'b001);

        // 99 idle cycles keep the partial packet
        w = 64'hBEEF_0001_C0DE_0002;
        send_bytes(w, 0, 2);
        send_idle(99);
        send_bytes(w, 3, 7);
        send_frame(1'b1, {1'b0, 3'b000, crc_ref(w[63:32], w[31:0], 3'b000)}, 1'b1);
        push(1'b1, w[63:32], w[31:0], 3'b000, F_NONE);

        // Reset in the payload of the third data byte
        send_idle(3);
        send_bytes(64'hFEDC_BA98_7654_3210, 0, 1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b1;
        m_a = '0; m_b = '0; m_op = '0;
        @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        send_idle(2);
        send_packet(32'h0000_00FF, 32'h0000_0100, 3'b100);

        // Zero stop bit on data byte 4
        w = 64'h1357_9BDF_2468_ACE0;
        send_bytes(w, 0, 2);
        send_frame(1'b0, w[39:32], 1'b0);
`ifdef SIN_FRAME_CHECK_EN
        push(1'b0, '0, '0, '0, F_DATA);
        send_idle(2);
        send_packet(w[63:32], w[31:0], 3'b000);
`else
        send_bytes(w, 4, 7);
        send_frame(1'b1, {1'b0, 3'b000, crc_ref(w[63:32], w[31:0], 3'b000)}, 1'b1);
        push(1'b1, w[63:32], w[31:0], 3'b000, F_NONE);
`endif

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        send_idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
